boot_sequencer: RTL
===================

BOOT_SEQUENCER -- requirements
Module: boot_sequencer

Interface
REQ-001 SHALL have parameter VDET_DEBOUNCE, default 16: consecutive stable cycles required before a usb_vdet change is accepted.
REQ-002 SHALL have parameter BOOT_DELAY, default 256: cycles spent in COUNT before programn is driven low.
REQ-003 SHALL have parameter PROGRAMN_LOW, default 8: cycles programn is held low.
REQ-004 SHALL have port clk, input, 1: single clock for all logic.
REQ-005 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have port boot_req, input, 1: single-cycle boot request pulse from the bootloader core, synchronous to clk.
REQ-007 SHALL have port usb_vdet, input, 1: USB VBUS detect, asynchronous to clk.
REQ-008 SHALL have port programn, output, 1: active-low FPGA reconfiguration request.
REQ-009 SHALL have port vdet_db, output, 1: synchronized and debounced usb_vdet.
REQ-010 SHALL have port state, output, 2: current FSM state, encoded IDLE=0, COUNT=1, ASSERT=2, DONE=3.
REQ-011 SHALL have port busy, output, 1: high whenever state is not IDLE.

Function
REQ-012 SHALL pass usb_vdet through a 2-flop synchronizer before any other use.
REQ-013 SHALL update vdet_db only on the cycle in which the synchronized value has differed from vdet_db for VDET_DEBOUNCE consecutive cycles.
REQ-014 SHALL clear the debounce counter on any cycle where the synchronized value equals vdet_db.
REQ-015 SHALL produce a vdet_db change exactly 2+VDET_DEBOUNCE cycles after a clean usb_vdet edge.
REQ-016 SHALL latch boot_req into a sticky boot_latched flag, cleared only by reset.
REQ-017 SHALL transition IDLE->COUNT when boot_req=1 or vdet_db=0, and SHALL clear the delay counter on entry.
REQ-018 SHALL increment the delay counter by 1 every cycle while in COUNT.
REQ-019 SHALL transition COUNT->IDLE and clear the counter when vdet_db=1 and both boot_latched=0 and boot_req=0.
REQ-020 SHALL make COUNT uncancellable once boot_latched=1, including boot_req arriving mid-COUNT.
REQ-021 SHALL give boot_req priority over cancellation when boot_req and a vdet_db rise coincide, so COUNT continues.
REQ-022 SHALL transition COUNT->ASSERT on the cycle after counter==BOOT_DELAY-1, so programn falls BOOT_DELAY cycles after COUNT entry.
REQ-023 SHALL drive programn=0 only in ASSERT, registered with no combinational path from inputs.
REQ-024 SHALL ignore all inputs while in ASSERT.
REQ-025 SHALL transition ASSERT->DONE after PROGRAMN_LOW cycles.
REQ-026 SHALL hold programn=1 in DONE and remain in DONE until reset.
REQ-027 SHALL size counters to $clog2 of the relevant parameter plus 1, so counters never wrap within a state.
REQ-028 SHALL be legal only for VDET_DEBOUNCE, BOOT_DELAY and PROGRAMN_LOW each >= 2, with an elaboration-time check enforcing this.

Reset
REQ-029 SHALL, on reset assertion and regardless of clk, immediately set: programn=1, state=IDLE, busy=0, vdet_db=1, synchronizer flops=1, all counters=0, boot_latched=0.
REQ-030 SHALL abort any state, including ASSERT, on reset mid-operation, with programn returning high asynchronously.
REQ-031 SHALL resume normal operation on the first clk edge after reset deasserts.

Verification
REQ-032 SHALL be covered by: usb_vdet held 1, single boot_req pulse -> programn low from cycle 256 to 263 after pulse, then DONE with programn=1.
REQ-033 SHALL be covered by: usb_vdet falls and stays 0 -> vdet_db falls 18 cycles later -> programn falls 256 cycles after COUNT entry.
REQ-034 SHALL be covered by: usb_vdet=0 long enough to enter COUNT, then back to 1 at counter approx. 100 -> return to IDLE with counter cleared and programn never low.
REQ-035 SHALL be covered by: vdet-initiated COUNT, boot_req at counter=50, then usb_vdet back to 1 -> no cancel, programn falls 256 cycles after original COUNT entry.
REQ-036 SHALL be covered by: usb_vdet glitch to 0 for 10 cycles -> vdet_db stays 1 and state stays IDLE.
REQ-037 SHALL be covered by: reset asserted during ASSERT -> programn=1 and state=IDLE immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/boot_sequencer.sv
// Boot sequencer: synchronizes and debounces USB VBUS detect, then after a
// boot request or VBUS loss counts BOOT_DELAY cycles and pulses the
// active-low programn output for PROGRAMN_LOW cycles before parking in DONE.
module boot_sequencer #(
    parameter int VDET_DEBOUNCE = 16,
    parameter int BOOT_DELAY    = 256,
    parameter int PROGRAMN_LOW  = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       boot_req,
    input  logic       usb_vdet,
    output logic       programn,
    output logic       vdet_db,
    output logic [1:0] state,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        COUNT  = 2'd1,
        ASSERT = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam int DB_W  = $clog2(VDET_DEBOUNCE) + 1;
    localparam int DLY_W = $clog2(BOOT_DELAY) + 1;
    localparam int LOW_W = $clog2(PROGRAMN_LOW) + 1;

    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(VDET_DEBOUNCE - 1);
    localparam logic [DLY_W-1:0] DLY_LAST = DLY_W'(BOOT_DELAY - 1);
    localparam logic [LOW_W-1:0] LOW_LAST = LOW_W'(PROGRAMN_LOW - 1);

    // Counters below assume at least two cycles per phase.
    if (VDET_DEBOUNCE < 2 || BOOT_DELAY < 2 || PROGRAMN_LOW < 2) begin : g_param_check
        $error("boot_sequencer: VDET_DEBOUNCE, BOOT_DELAY and PROGRAMN_LOW must each be >= 2");
    end

    state_t            cur_state;
    logic              vdet_p0;
    logic              vdet_p1;
    logic [DB_W-1:0]   db_cnt;
    logic [DLY_W-1:0]  dly_cnt;
    logic [LOW_W-1:0]  low_cnt;
    logic              boot_latched;

    assign state = cur_state;

    // Two-flop synchronizer for the asynchronous VBUS detect; idles high.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vdet_p0 <= 1'b1;
            vdet_p1 <= 1'b1;
        end else begin
            vdet_p0 <= usb_vdet;
            vdet_p1 <= vdet_p0;
        end
    end

    // Debounce: accept a new level only after it has differed for VDET_DEBOUNCE cycles in a row.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vdet_db <= 1'b1;
            db_cnt  <= '0;
        end else if (vdet_p1 == vdet_db) begin
            db_cnt  <= '0;
        end else if (db_cnt == DB_LAST) begin
            vdet_db <= vdet_p1;
            db_cnt  <= '0;
        end else begin
            db_cnt  <= db_cnt + DB_W'(1);
        end
    end

    // Sticky record of a bootloader request; once set, the countdown cannot be cancelled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            boot_latched <= 1'b0;
        end else if (boot_req) begin
            boot_latched <= 1'b1;
        end
    end

    // Sequencer FSM with registered programn/busy outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur_state <= IDLE;
            programn  <= 1'b1;
            busy      <= 1'b0;
            dly_cnt   <= '0;
            low_cnt   <= '0;
        end else begin
            case (cur_state)
                IDLE: begin
                    if (boot_req || !vdet_db) begin
                        cur_state <= COUNT;
                        busy      <= 1'b1;
                        dly_cnt   <= '0;
                    end
                end
                COUNT: begin
                    // A boot request on this very cycle wins over a VBUS-return cancel.
                    if (vdet_db && !boot_latched && !boot_req) begin
                        cur_state <= IDLE;
                        busy      <= 1'b0;
                        dly_cnt   <= '0;
                    end else if (dly_cnt == DLY_LAST) begin
                        cur_state <= ASSERT;
                        programn  <= 1'b0;
                        low_cnt   <= '0;
                    end else begin
                        dly_cnt   <= dly_cnt + DLY_W'(1);
                    end
                end
                ASSERT: begin
                    if (low_cnt == LOW_LAST) begin
                        cur_state <= DONE;
                        programn  <= 1'b1;
                    end else begin
                        low_cnt   <= low_cnt + LOW_W'(1);
                    end
                end
                DONE: begin
                    cur_state <= DONE;
                end
                default: begin
                    cur_state <= IDLE;
                    programn  <= 1'b1;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule
